// File: rtl/tt_pwm_pkg.sv
// Shared constants and elaboration checks for the Tiny Tapeout PWM block.
// Address map and parameter limits live here so the top and bench agree.
package tt_pwm_pkg;

  localparam logic [3:0] ADDR_PRESC = 4'd8;
  localparam logic [3:0] ADDR_EN    = 4'd9;

  localparam int MAX_CH         = 8;
  localparam int MAX_CNT_W      = 8;
  localparam int MAX_PRESCALE_W = 8;

  function automatic bit in_range(
    input int v,
    input int lo,
    input int hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/tt_pwm_strobe_sync.sv
// Brings the asynchronous write strobe into the clk domain and turns
// each rising edge into a single-cycle pulse.
module tt_pwm_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse_out
);

  logic [2:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], async_in};
    end
  end

  assign pulse_out = sync[1] & ~sync[2];

endmodule

// File: rtl/tt_um_kevinwguan_pwm8.sv
// N_CH-channel PWM generator configured by strobed byte writes.
// Define SHADOW_EN for period-aligned (shadowed) duty/en_mask updates.
import tt_pwm_pkg::*;

module tt_um_kevinwguan_pwm8 #(
  parameter int N_CH       = 8,
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       VGND,
  input  logic       VPWR,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  inout  wire  [7:0] ua
);

  if (!in_range(N_CH, 1, MAX_CH) ||
      !in_range(CNT_W, 1, MAX_CNT_W) ||
      !in_range(PRESCALE_W, 1, MAX_PRESCALE_W)) begin : g_bad_cfg
    $error("tt_um_kevinwguan_pwm8: parameter out of range");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                         wr_pulse;
  logic                         wr;
  logic [3:0]                   addr;
  logic [PRESCALE_W-1:0]        presc;
  logic [PRESCALE_W-1:0]        pre_cnt;
  logic [CNT_W-1:0]             cnt;
  logic                         tick;
  logic                         wrap;
  logic [N_CH-1:0][CNT_W-1:0]   duty;
  logic [N_CH-1:0]              en_mask;
  logic [7:0]                   hit;

  tt_pwm_strobe_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (uio_in[7]),
    .pulse_out (wr_pulse)
  );

  assign wr   = wr_pulse & ena;
  assign addr = uio_in[3:0];
  assign tick = ena & (pre_cnt == presc);
  assign wrap = tick & (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pre_cnt <= '0;
    end else if (wr && addr == ADDR_PRESC) begin
      presc   <= ui_in[PRESCALE_W-1:0];
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else if (ena) begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef SHADOW_EN
  logic [N_CH-1:0][CNT_W-1:0] duty_sh;
  logic [N_CH-1:0]            en_sh;

  // Active copy reloads on the wrap tick, so a write landing in the
  // same cycle is held back until the following period.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh <= '0;
      en_sh   <= '0;
      duty    <= '0;
      en_mask <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr && addr == 4'(i)) begin
          duty_sh[i] <= ui_in[CNT_W-1:0];
        end
      end
      if (wr && addr == ADDR_EN) begin
        en_sh <= ui_in[N_CH-1:0];
      end
      if (wrap) begin
        duty    <= duty_sh;
        en_mask <= en_sh;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      duty    <= '0;
      en_mask <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr && addr == 4'(i)) begin
          duty[i] <= ui_in[CNT_W-1:0];
        end
      end
      if (wr && addr == ADDR_EN) begin
        en_mask <= ui_in[N_CH-1:0];
      end
    end
  end
`endif

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < N_CH) begin : g_on
      assign hit[i] = en_mask[i] & (cnt < duty[i]);
    end else begin : g_off
      assign hit[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out <= '0;
    end else begin
      uo_out <= ena ? hit : 8'h00;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused;
  assign unused = &{1'b0, VGND, VPWR, uio_in[6:4], ui_in, ua, wrap};

endmodule

// File: tb/tb_tt_um_kevinwguan_pwm8.sv
// Randomized + directed bench for tt_um_kevinwguan_pwm8 against a
// tick-count reference model of the PWM rules.
module tb_tt_um_kevinwguan_pwm8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       VGND = 1'b0;
  logic       VPWR = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;
  wire  [7:0] ua;

  int total = 0;
  int bad = 0;
  int hi[8];

  always #5 clk = ~clk;

  tt_um_kevinwguan_pwm8 dut (
    .clk     (clk),
    .rst     (rst),
    .VGND    (VGND),
    .VPWR    (VPWR),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ua      (ua)
  );

  // Reference: total ticks mod 256 is the PWM phase; writes land on
  // the third edge after the strobe pin is first seen high.
  int unsigned m_duty[8];
  int unsigned m_sduty[8];
  logic [7:0]  m_mask;
  logic [7:0]  m_smask;
  int unsigned m_presc;
  int unsigned m_phase;
  int unsigned m_ticks;
  logic [7:0]  m_out;
  bit          m_prev, m_p0, m_p1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          wr, rise, tick;
    logic [7:0]  nout;
    int unsigned c, a, d;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_duty[i] = 0;
        m_sduty[i] = 0;
      end
      m_mask = 0; m_smask = 0; m_presc = 0; m_phase = 0;
      m_ticks = 0; m_out = 0; m_prev = 0; m_p0 = 0; m_p1 = 0;
      return;
    end
    c = m_ticks % 256;
    nout = 8'h00;
    if (ena)
      for (int i = 0; i < 8; i++)
        nout[i] = m_mask[i] && (c < m_duty[i]);
    tick = ena && (m_phase == m_presc);
    wr = m_p1 && ena;
    rise = uio_in[7] && !m_prev;
    m_prev = uio_in[7];
    m_p1 = m_p0;
    m_p0 = rise;
    a = uio_in[3:0];
    d = ui_in;
    if (wr && a == 8) begin
      m_presc = d;
      m_phase = 0;
    end else if (ena) begin
      m_phase = tick ? 0 : m_phase + 1;
    end
    if (tick) m_ticks = (m_ticks + 1) % 256;
`ifdef SHADOW_EN
    if (tick && c == 255) begin
      m_duty = m_sduty;
      m_mask = m_smask;
    end
    if (wr && a < 8) m_sduty[a] = d;
    if (wr && a == 9) m_smask = d[7:0];
`else
    if (wr && a < 8) m_duty[a] = d;
    if (wr && a == 9) m_mask = d[7:0];
`endif
    m_out = nout;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("uo_out", {24'h0, uo_out}, {24'h0, m_out});
    for (int i = 0; i < 8; i++)
      if (uo_out[i]) hi[i]++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    for (int i = 0; i < 8; i++) hi[i] = 0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d,
                        input int hold);
    uio_in = {4'h0, a};
    ui_in = d;
    step();
    uio_in[7] = 1'b1;
    repeat (hold) step();
    uio_in[7] = 1'b0;
    run(3);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    run(2);
    chk("rst_uo", {24'h0, uo_out}, 32'h0);
    chk("rst_oe", {24'h0, uio_oe}, 32'h0);
    chk("rst_uio_out", {24'h0, uio_out}, 32'h0);
    rst = 1'b0;

    // Basic duty ratios at presc=0
    wr_reg(4'd8, 8'd0, 3);
    wr_reg(4'd9, 8'hFF, 3);
    wr_reg(4'd0, 8'd64, 3);
    wr_reg(4'd1, 8'd0, 2);
    wr_reg(4'd2, 8'd255, 4);
    run(260);
    clr();
    run(256);
    chk("duty64", hi[0], 64);
    chk("duty0", hi[1], 0);
    chk("duty255", hi[2], 255);

    // Prescaler and mid-period presc rewrite
    wr_reg(4'd0, 8'd128, 3);
    wr_reg(4'd8, 8'd3, 3);
    run(1030);
    clr();
    run(1024);
    chk("presc3_high", hi[0], 512);
    run(300);
    wr_reg(4'd8, 8'd0, 3);
    run(260);
    clr();
    run(256);
    chk("presc0_high", hi[0], 128);

    // Long strobe: one write with the first data; addr 12 ignored
    uio_in = 8'h03;
    ui_in = 8'd100;
    step();
    uio_in[7] = 1'b1;
    run(5);
    ui_in = 8'd7;
    run(15);
    uio_in[7] = 1'b0;
    run(3);
    wr_reg(4'd12, 8'd0, 3);
    run(260);
    clr();
    run(256);
    chk("held_strobe", hi[3], 100);
    chk("addr12", hi[0], 128);

    // ena drop: outputs off, writes dropped, resume
    run(77);
    ena = 1'b0;
    step();
    chk("ena_off", {24'h0, uo_out}, 32'h0);
    run(5);
    wr_reg(4'd0, 8'd0, 3);
    run(5);
    ena = 1'b1;
    run(260);
    clr();
    run(256);
    chk("ena_write_dropped", hi[0], 128);

    // Duty change mid-period
    wr_reg(4'd0, 8'd64, 3);
    run(400);
    wr_reg(4'd0, 8'd200, 2);
    run(300);
    clr();
    run(256);
    chk("duty200", hi[0], 200);

    // Reset mid-run
    run(50);
    rst = 1'b1;
    run(2);
    chk("midrst_uo", {24'h0, uo_out}, 32'h0);
    chk("midrst_oe", {24'h0, uio_oe}, 32'h0);
    rst = 1'b0;
    wr_reg(4'd9, 8'hFF, 3);
    run(260);
    clr();
    run(256);
    chk("post_rst_ch0", hi[0], 0);
    chk("post_rst_ch2", hi[2], 0);

    // Randomized traffic, every cycle checked against the model
    for (int it = 0; it < 80; it++) begin
      int unsigned sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 2));
        rst = 1'b0;
      end else if (sel < 4) begin
        ena = ($urandom_range(0, 3) != 0);
        run($urandom_range(1, 40));
      end else if (sel < 6) begin
        wr_reg(4'd8, 8'($urandom_range(0, 5)), $urandom_range(2, 6));
      end else if (sel < 14) begin
        wr_reg(4'($urandom_range(0, 15)), 8'($urandom),
               $urandom_range(2, 8));
      end else begin
        run($urandom_range(1, 300));
      end
    end
    ena = 1'b1;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
